image_stream_writer: RTL

IMAGE_STREAM_WRITER -- requirements
Module: image_stream_writer

---
 rtl/image_stream_writer.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/image_stream_writer.sv
// image_stream_writer: captures one grayscale frame into an internal frame
// memory, then streams it out as a complete 24-bit BMP file, one byte per
// transfer.
// Optional feature macro: IMAGE_WRITER_ROW_PAD_EN -- when defined, each BMP row
// is zero-padded to a 4-byte multiple; when undefined, rows are unpadded and
// the header sizes follow.
module image_stream_writer #(
  parameter int unsigned WIDTH        = 320,
  parameter int unsigned HEIGHT       = 240,
  parameter int unsigned PIX_PER_BEAT = 2
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [8*PIX_PER_BEAT-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                out_data,
  output logic                      out_last,
  output logic                      Write_Done,
  output logic [15:0]               frame_cnt
);

  localparam int unsigned NPIX   = WIDTH * HEIGHT;
  localparam int unsigned AW     = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned ROWPIX = WIDTH * 3;
`ifdef IMAGE_WRITER_ROW_PAD_EN
  localparam int unsigned ROWBYTES = ((ROWPIX + 3) / 4) * 4;
`else
  localparam int unsigned ROWBYTES = ROWPIX;
`endif
  localparam int unsigned PADB      = ROWBYTES - ROWPIX;
  localparam int unsigned IMG_SIZE  = ROWBYTES * HEIGHT;
  localparam int unsigned FILE_SIZE = 54 + IMG_SIZE;

  localparam logic [AW-1:0] LAST_BEAT = AW'(NPIX - PIX_PER_BEAT);
  localparam logic [AW-1:0] TOP_ROW   = AW'((HEIGHT - 1) * WIDTH);
  localparam logic [AW-1:0] ROW_STEP  = AW'(WIDTH);
  localparam logic [CW-1:0] LAST_COL  = CW'(WIDTH - 1);
  localparam logic [1:0]    LAST_PAD  = 2'(PADB - 1);

  typedef enum logic [2:0] {
    CAPTURE,
    HEADER,
    PIXELS,
    PAD,
    DONE
  } state_t;

  state_t state, next_state;

  logic [7:0]    mem [NPIX];
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_base;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] col;
  logic [1:0]    rep;
  logic [1:0]    pad_cnt;
  logic [5:0]    hdr_idx;
  logic          gen_end;
  logic          in_fire;
  logic          out_fire;
  logic          load;
  logic          row_end;
  logic          cur_last;
  logic [7:0]    cur_byte;

  // Header fields from offset 2 onward are all 4-byte aligned relative to
  // offset 2; planes (16) and bpp (16) share one little-endian word.
  function automatic logic [7:0] hdr_byte(input logic [5:0] idx);
    logic [5:0]  off;
    logic [31:0] w;
    off = idx - 6'd2;
    w   = '0;
    case (off[5:2])
      4'd0:    w = FILE_SIZE;
      4'd2:    w = 32'd54;
      4'd3:    w = 32'd40;
      4'd4:    w = WIDTH;
      4'd5:    w = HEIGHT;
      4'd6:    w = 32'h0018_0001;
      4'd8:    w = IMG_SIZE;
      default: w = '0;
    endcase
    if (idx == 6'd0)      hdr_byte = 8'h42;
    else if (idx == 6'd1) hdr_byte = 8'h4D;
    else                  hdr_byte = w[{off[1:0], 3'b000} +: 8];
  endfunction

  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign load       = ((state == HEADER) || (state == PIXELS) || (state == PAD)) &&
                      !gen_end && (!out_valid || out_ready);
  assign rd_addr    = rd_base + AW'(col);
  assign row_end    = (col == LAST_COL) && (rep == 2'd2);
  assign Write_Done = (state == DONE);

  // Byte the generator would present next, and whether it ends the file.
  always_comb begin
    cur_byte = '0;
    cur_last = 1'b0;
    case (state)
      HEADER: cur_byte = hdr_byte(hdr_idx);
      PIXELS: begin
        cur_byte = mem[rd_addr];
        cur_last = (PADB == 0) && (rd_base == '0) && row_end;
      end
      PAD:    cur_last = (rd_base == '0) && (pad_cnt == LAST_PAD);
      default: ;
    endcase
  end

  // Next-state logic; DONE follows the transfer of the final byte, not its load.
  always_comb begin
    next_state = state;
    case (state)
      CAPTURE: if (in_fire && (wr_addr == LAST_BEAT)) next_state = HEADER;
      HEADER:  if (load && (hdr_idx == 6'd53)) next_state = PIXELS;
      PIXELS: begin
        if (out_fire && out_last) next_state = DONE;
        else if (load && row_end && !cur_last && (PADB != 0)) next_state = PAD;
      end
      PAD: begin
        if (out_fire && out_last) next_state = DONE;
        else if (load && (pad_cnt == LAST_PAD) && !cur_last) next_state = PIXELS;
      end
      DONE:    next_state = CAPTURE;
      default: next_state = CAPTURE;
    endcase
  end

  // State register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= CAPTURE;
    else          state <= next_state;
  end

  // in_ready is registered so it stays low during reset and drops right after the last beat.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) in_ready <= 1'b0;
    else          in_ready <= (next_state == CAPTURE);
  end

  // Raster-order write pointer for the captured frame.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)              wr_addr <= '0;
    else if (state != CAPTURE) wr_addr <= '0;
    else if (in_fire)          wr_addr <= (wr_addr == LAST_BEAT) ? '0 : wr_addr + AW'(PIX_PER_BEAT);
  end

  // Frame memory write; contents survive reset.
  always_ff @(posedge HCLK) begin
    if (in_fire) begin
      for (int unsigned p = 0; p < PIX_PER_BEAT; p++) begin
        mem[wr_addr + AW'(p)] <= in_data[8*p +: 8];
      end
    end
  end

  // Output-position counters: header index, bottom-up row base, column, byte repeat, pad.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hdr_idx <= '0;
      rd_base <= '0;
      col     <= '0;
      rep     <= '0;
      pad_cnt <= '0;
      gen_end <= 1'b0;
    end else if ((state == CAPTURE) || (state == DONE)) begin
      hdr_idx <= '0;
      rd_base <= TOP_ROW;
      col     <= '0;
      rep     <= '0;
      pad_cnt <= '0;
      gen_end <= 1'b0;
    end else if (load) begin
      if (cur_last) gen_end <= 1'b1;
      case (state)
        HEADER: hdr_idx <= hdr_idx + 6'd1;
        PIXELS: begin
          if (rep == 2'd2) begin
            rep <= '0;
            if (col == LAST_COL) begin
              col <= '0;
              if ((PADB == 0) && (rd_base != '0)) rd_base <= rd_base - ROW_STEP;
            end else begin
              col <= col + CW'(1);
            end
          end else begin
            rep <= rep + 2'd1;
          end
        end
        PAD: begin
          if (pad_cnt == LAST_PAD) begin
            pad_cnt <= '0;
            if (rd_base != '0) rd_base <= rd_base - ROW_STEP;
          end else begin
            pad_cnt <= pad_cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output register: reloads on accept, otherwise holds the byte through stalls.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= cur_byte;
      out_last  <= cur_last;
    end else if (out_fire) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  // Completed-file counter, wraps naturally at 16 bits.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)           frame_cnt <= '0;
    else if (state == DONE) frame_cnt <= frame_cnt + 16'd1;
  end

endmodule
